// File: rtl/cpu_pkg.sv
// Shared definitions for the ID/EX operand-delivery path.
// Holds the datapath sizes, the forwarding-select encoding and the
// ALU-B source encoding. The other files import it.
package cpu_pkg;

  localparam int DW       = 64;  // datapath width
  localparam int RW       = 5;   // register index width
  localparam int ZERO_REG = 31;  // XZR: reads as zero, so it is never forwarded

  // Where an ID source operand comes from.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Which value feeds the ALU's second operand in EX.
  typedef enum logic [1:0] {
    SRC_REG    = 2'b00,
    SRC_DADDR9 = 2'b01,
    SRC_IMM12  = 2'b10
  } alu_src_t;

endpackage

// File: rtl/dff_sync_rstn.sv
// One-bit D flip-flop with a synchronous active-low clear.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, wins over d
//   d / q : data in / registered data out
module dff_sync_rstn (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/ex_operand_select_fwd_unit.sv
// Forwarding select logic for the ID source operands. Purely combinational.
//   src            : source register index per operand (0 = A, 1 = B)
//   rd_ex, wen_ex  : destination / write enable of the instruction in EX
//   rd_mem, wen_mem: destination / write enable of the instruction in MEM
//   sel            : per-operand select, encoded as cpu_pkg::fwd_sel_t
// The younger EX result wins over MEM; XZR is never forwarded because
// its architectural value is always zero.
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int RW       = cpu_pkg::RW,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG,
  parameter int NUM_OPS  = 2
) (
  input  logic [NUM_OPS-1:0][RW-1:0] src,
  input  logic [RW-1:0]              rd_ex,
  input  logic                       wen_ex,
  input  logic [RW-1:0]              rd_mem,
  input  logic                       wen_mem,
  output logic [NUM_OPS-1:0][1:0]    sel
);

  localparam logic [RW-1:0] ZR = RW'(ZERO_REG);

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    logic not_zr, hit_ex, hit_mem;
    assign not_zr  = (src[i] != ZR);
    assign hit_ex  = wen_ex  && (rd_ex  == src[i]) && not_zr;
    assign hit_mem = wen_mem && (rd_mem == src[i]) && not_zr;
    assign sel[i]  = hit_ex  ? FWD_EX  :
                     hit_mem ? FWD_MEM : FWD_RF;
  end

endmodule

// File: rtl/ex_operand_select.sv
// Operand delivery between register-file read (ID) and the ALU (EX).
//   ID side : rn / reg_ab select sources, rf_data1/2 are the register-file
//             reads, rd_*/wen_* and *_result describe the EX and MEM
//             instructions for forwarding; daddr9, imm12, alu_src are the
//             immediate fields and ALU-B source select.
//   ID outs : fwd_sel_a/b (forwarding selects), opnd_b_id (forwarded B for
//             CBZ) and b_zero_id (opnd_b_id == 0).
//   EX outs : alu_a (registered A), alu_b (source-muxed B) and store_data
//             (registered B, independent of alu_src).
// The ID/EX register loads every cycle; rst_n clears it synchronously.
module ex_operand_select
  import cpu_pkg::*;
#(
  parameter int DW       = cpu_pkg::DW,
  parameter int RW       = cpu_pkg::RW,
  parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] rn,
  input  logic [RW-1:0] reg_ab,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  input  logic [RW-1:0] rd_ex,
  input  logic          wen_ex,
  input  logic [RW-1:0] rd_mem,
  input  logic          wen_mem,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] mem_result,
  input  logic [8:0]    daddr9,
  input  logic [11:0]   imm12,
  input  logic [1:0]    alu_src,
  output logic [1:0]    fwd_sel_a,
  output logic [1:0]    fwd_sel_b,
  output logic [DW-1:0] opnd_b_id,
  output logic          b_zero_id,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] store_data
);

  // Everything that crosses the ID/EX boundary.
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] daddr9_ext;
    logic [DW-1:0] imm12_ext;
    logic [1:0]    alu_src;
  } idex_t;

  localparam int PW = $bits(idex_t);

  // ---------------- ID: forwarding ----------------
  logic [1:0][RW-1:0] src;
  logic [1:0][1:0]    sel;

  assign src[0] = rn;
  assign src[1] = reg_ab;

  fwd_unit #(
    .RW       (RW),
    .ZERO_REG (ZERO_REG),
    .NUM_OPS  (2)
  ) u_fwd (
    .src     (src),
    .rd_ex   (rd_ex),
    .wen_ex  (wen_ex),
    .rd_mem  (rd_mem),
    .wen_mem (wen_mem),
    .sel     (sel)
  );

  assign fwd_sel_a = sel[0];
  assign fwd_sel_b = sel[1];

  // An unexpected 2'b11 falls back to the register-file value.
  function automatic logic [DW-1:0] fwd_mux(input logic [1:0]    s,
                                            input logic [DW-1:0] rf,
                                            input logic [DW-1:0] ex,
                                            input logic [DW-1:0] mem);
    case (s)
      FWD_EX:  return ex;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

  logic [DW-1:0] opnd_a_id;

  assign opnd_a_id = fwd_mux(sel[0], rf_data1, ex_result, mem_result);
  assign opnd_b_id = fwd_mux(sel[1], rf_data2, ex_result, mem_result);
  assign b_zero_id = ~|opnd_b_id;

  // ---------------- ID/EX register ----------------
  idex_t         id_d, ex_q;
  logic [PW-1:0] id_bits, ex_bits;

  always_comb begin
    id_d            = '0;
    id_d.a          = opnd_a_id;
    id_d.b          = opnd_b_id;
    id_d.daddr9_ext = {{(DW-9){daddr9[8]}}, daddr9};
    id_d.imm12_ext  = {{(DW-12){1'b0}}, imm12};
    id_d.alu_src    = alu_src;
  end

  assign id_bits = id_d;

  for (genvar i = 0; i < PW; i++) begin : g_idex
    dff_sync_rstn u_dff (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (id_bits[i]),
      .q     (ex_bits[i])
    );
  end

  assign ex_q = idex_t'(ex_bits);

  // ---------------- EX: ALU-B source ----------------
  // 2'b11 has no encoding and yields zero.
  always_comb begin
    alu_b = '0;
    case (ex_q.alu_src)
      SRC_REG:    alu_b = ex_q.b;
      SRC_DADDR9: alu_b = ex_q.daddr9_ext;
      SRC_IMM12:  alu_b = ex_q.imm12_ext;
      default:    alu_b = '0;
    endcase
  end

  assign alu_a      = ex_q.a;
  assign store_data = ex_q.b;

endmodule

// File: tb/tb_ex_operand_select.sv
module tb_ex_operand_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rn, reg_ab, rd_ex, rd_mem;
  logic        wen_ex, wen_mem;
  logic [63:0] rf_data1, rf_data2, ex_result, mem_result;
  logic [8:0]  daddr9;
  logic [11:0] imm12;
  logic [1:0]  alu_src;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [63:0] opnd_b_id, alu_a, alu_b, store_data;
  logic        b_zero_id;

  always #5 clk = ~clk;

  ex_operand_select dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rn         (rn),
    .reg_ab     (reg_ab),
    .rf_data1   (rf_data1),
    .rf_data2   (rf_data2),
    .rd_ex      (rd_ex),
    .wen_ex     (wen_ex),
    .rd_mem     (rd_mem),
    .wen_mem    (wen_mem),
    .ex_result  (ex_result),
    .mem_result (mem_result),
    .daddr9     (daddr9),
    .imm12      (imm12),
    .alu_src    (alu_src),
    .fwd_sel_a  (fwd_sel_a),
    .fwd_sel_b  (fwd_sel_b),
    .opnd_b_id  (opnd_b_id),
    .b_zero_id  (b_zero_id),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .store_data (store_data)
  );

  typedef struct {
    bit        rst_n;
    bit [4:0]  rn, reg_ab, rd_ex, rd_mem;
    bit        wen_ex, wen_mem;
    bit [63:0] rf1, rf2, exr, memr;
    bit [8:0]  daddr9;
    bit [11:0] imm12;
    bit [1:0]  alu_src;
  } stim_t;

  typedef struct { bit [1:0] sa, sb; bit [63:0] ob; bit bz; } comb_t;
  typedef struct { bit [63:0] a, b, sd; } reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];
  int    checks = 0;
  int    passes = 0;

  // ---------------- reference model ----------------
  // Which producer supplies a register: the newest writer in flight,
  // except XZR which always reads the register file.
  function automatic bit [1:0] model_sel(bit [4:0] r, stim_t s);
    if (r == 5'd31)                   return 2'd0;
    if (s.wen_ex  && s.rd_ex  == r)   return 2'd1;
    if (s.wen_mem && s.rd_mem == r)   return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit [63:0] model_val(bit [1:0] sel, bit [63:0] rf, stim_t s);
    if (sel == 2'd1) return s.exr;
    if (sel == 2'd2) return s.memr;
    return rf;
  endfunction

  task automatic issue(input stim_t s);
    comb_t c;
    reg_t  r;
    bit signed [8:0] off;
    longint          off64;
    bit [63:0]       a, b;
    rst_n = s.rst_n;  rn = s.rn;  reg_ab = s.reg_ab;
    rf_data1 = s.rf1; rf_data2 = s.rf2;
    rd_ex = s.rd_ex;  wen_ex = s.wen_ex;  rd_mem = s.rd_mem;  wen_mem = s.wen_mem;
    ex_result = s.exr; mem_result = s.memr;
    daddr9 = s.daddr9; imm12 = s.imm12; alu_src = s.alu_src;

    c.sa = model_sel(s.rn, s);
    c.sb = model_sel(s.reg_ab, s);
    a    = model_val(c.sa, s.rf1, s);
    b    = model_val(c.sb, s.rf2, s);
    c.ob = b;
    c.bz = (b == 64'd0);
    comb_q.push_back(c);

    off   = s.daddr9;
    off64 = off;                 // numeric sign extension of the offset
    if (!s.rst_n) begin
      r.a = 0; r.b = 0; r.sd = 0;
    end else begin
      r.a  = a;
      r.sd = b;
      case (s.alu_src)
        2'd0:    r.b = b;
        2'd1:    r.b = off64;
        2'd2:    r.b = 64'(s.imm12);
        default: r.b = 64'd0;
      endcase
    end
    reg_q.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input bit [63:0] exp);
    checks++;
    if (act === {1'b0, exp}[63:0]) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  // Combinational outputs belong to the inputs of the current cycle;
  // registered outputs belong to the previous cycle's item.
  initial begin
    comb_t c;
    reg_t  r;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("fwd_sel_a", 64'(fwd_sel_a), 64'(c.sa));
        chk("fwd_sel_b", 64'(fwd_sel_b), 64'(c.sb));
        chk("opnd_b_id", opnd_b_id, c.ob);
        chk("b_zero_id", 64'(b_zero_id), 64'(c.bz));
      end
      if (reg_q.size() >= 2) begin
        r = reg_q.pop_front();
        chk("alu_a", alu_a, r.a);
        chk("alu_b", alu_b, r.b);
        chk("store_data", store_data, r.sd);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit [4:0] rnd_reg();
    int k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  function automatic bit [63:0] rnd_data();
    if ($urandom_range(0, 3) == 0) return 64'd0;
    return {$urandom, $urandom};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  initial begin
    stim_t s;
    stim_t dir[$];

    // reset with everything nonzero
    s = '{rst_n: 0, rn: 1, reg_ab: 2, rd_ex: 1, rd_mem: 2, wen_ex: 1, wen_mem: 1,
          rf1: 64'h77, rf2: 64'h88, exr: 64'h99, memr: 64'h66,
          daddr9: 9'h1AB, imm12: 12'h123, alu_src: 2'd1};
    dir.push_back(s);
    s = idle(); s.rn = 3; s.rf1 = 64'h5;                                    dir.push_back(s);
    s = idle(); s.rn = 4; s.rd_ex = 4; s.wen_ex = 1; s.exr = 64'hAA; s.rf1 = 64'h11; dir.push_back(s);
    s = idle(); s.reg_ab = 7; s.rd_ex = 7; s.wen_ex = 1; s.rd_mem = 7; s.wen_mem = 1;
    s.exr = 64'h1; s.memr = 64'h2; s.rf2 = 64'h33;                          dir.push_back(s);
    s.wen_ex = 0;                                                           dir.push_back(s);
    s = idle(); s.rn = 31; s.rd_ex = 31; s.wen_ex = 1; s.exr = 64'h44; s.rf1 = 64'h12; dir.push_back(s);
    s = idle(); s.rn = 5; s.rd_mem = 5; s.wen_mem = 0; s.memr = 64'h55; s.rf1 = 64'h13; dir.push_back(s);
    s = idle(); s.daddr9 = 9'h1F8; s.alu_src = 2'd1; s.reg_ab = 2; s.rf2 = 64'h1234; dir.push_back(s);
    s = idle(); s.imm12 = 12'hFFF; s.alu_src = 2'd2; s.reg_ab = 2; s.rf2 = 64'h5678; dir.push_back(s);
    s = idle(); s.reg_ab = 9; s.rd_mem = 9; s.wen_mem = 1; s.memr = 64'h0; s.rf2 = 64'h3; dir.push_back(s);
    s.memr = 64'h1;                                                         dir.push_back(s);
    s = idle(); s.alu_src = 2'd3; s.rf2 = 64'hDEAD; s.imm12 = 12'h1; s.daddr9 = 9'h1; dir.push_back(s);

    rst_n = 1'b0; rn = '0; reg_ab = '0; rf_data1 = '0; rf_data2 = '0;
    rd_ex = '0; wen_ex = 1'b0; rd_mem = '0; wen_mem = 1'b0;
    ex_result = '0; mem_result = '0; daddr9 = '0; imm12 = '0; alu_src = '0;

    @(posedge clk); #1;
    foreach (dir[i]) begin
      issue(dir[i]);
      @(posedge clk); #1;
    end

    for (int n = 0; n < 300; n++) begin
      s.rst_n   = ($urandom_range(0, 19) != 0);
      s.rn      = rnd_reg();
      s.reg_ab  = rnd_reg();
      s.rd_ex   = rnd_reg();
      s.rd_mem  = rnd_reg();
      s.wen_ex  = 1'($urandom_range(0, 1));
      s.wen_mem = 1'($urandom_range(0, 1));
      s.rf1     = rnd_data();
      s.rf2     = rnd_data();
      s.exr     = rnd_data();
      s.memr    = rnd_data();
      s.daddr9  = 9'($urandom);
      s.imm12   = 12'($urandom);
      s.alu_src = 2'($urandom_range(0, 3));
      issue(s);
      @(posedge clk); #1;
    end

    // drain the last registered item
    issue(idle());
    @(posedge clk); #1;
    issue(idle());
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
